mux16_scan_ctrl: RTL and testbench
==================================

// Module: mux16_scan_ctrl
// PURPOSE
//  Scan controller sitting upstream of the 16:1 select mux: drives its 4-bit select, waits a
//  settle time, samples the 1-bit mux output, and assembles the 16 samples into one frame.
//  Completed frames go downstream over a valid/ready handshake. Supports one-shot sweeps
//  (start pulse) and continuous sweeps (cont level), plus a per-channel enable mask.
// PARAMETERS
//  SETTLE_CYC  1   cycles sel is held before sampling; legal range 1..255
// PORTS
//  clk          in   1   single clock, rising edge
//  rst_n        in   1   asynchronous, active-low reset
//  start        in   1   one-cycle pulse; begins one sweep when IDLE
//  cont         in   1   level; while high, sweeps restart back-to-back
//  ch_mask      in   16  channel enables, latched at sweep start; bit i=0 -> channel i skipped
//  sel          out  4   select to the 16:1 mux
//  mux_out      in   1   output of the 16:1 mux
//  frame        out  16  completed frame; bit i = sample of channel i
//  frame_valid  out  1   frame holds a complete sweep
//  frame_ready  in   1   downstream accepts frame when frame_valid & frame_ready
//  busy         out  1   high while a sweep is in progress (state != IDLE)
//  overrun      out  1   sticky; a completed sweep was dropped
// BEHAVIOUR
//  - Reset: sel=0, frame=0, frame_valid=0, busy=0, overrun=0, state=IDLE, shadow=0.
//    Async assertion mid-sweep discards the partial frame immediately.
//  - States: IDLE, SETTLE, SAMPLE, DONE.
//  - IDLE: sel=0. On (start | cont), latch ch_mask into mask_q, ch=0, clear overrun if start=1,
//    go SETTLE. start while busy is ignored.
//  - SETTLE: sel=ch. If mask_q[ch]=0: shadow[ch]<=0, advance (ch+1, or DONE at ch=15) in 1 cycle.
//    Otherwise hold SETTLE_CYC cycles, then go SAMPLE.
//  - SAMPLE (1 cycle, sel=ch unchanged): shadow[ch]<=mux_out. At ch=15 go DONE, else ch+1 -> SETTLE.
//  - DONE (1 cycle): if frame_valid=0, or frame_valid & frame_ready in this cycle:
//    frame<=shadow and frame_valid<=1. Else the new frame is dropped, overrun<=1, frame unchanged.
//    Next state: SETTLE (relatch ch_mask, ch=0) if cont=1, else IDLE.
//  - frame_valid clears on accept unless DONE reloads it in the same cycle.
//  - frame and frame_valid are stable while frame_valid=1 and frame_ready=0.
//  - Latency: start sampled at edge k. Then frame_valid rises at edge k + E*(SETTLE_CYC+1) + M + 1,
//    where E = enabled channels and M = masked channels.
//  - Deasserting cont mid-sweep finishes the current sweep, then returns to IDLE.
//  - ch is 4-bit; it is never incremented past 15 (DONE is taken instead).
//  - Settle counter width: $clog2(SETTLE_CYC+1). The counter reloads on every entry to SETTLE.
//  - sel changes only on SETTLE entry; it never glitches within a channel's settle/sample window.
// STRUCTURE
//  - Package mux16_scan_pkg: NCH=16, SEL_W=4, typedef enum logic [1:0] scan_state_t
//    {IDLE, SETTLE, SAMPLE, DONE}.
//  - One sub-module: scan_settle_timer (loadable down-counter with done flag, param SETTLE_CYC).
//  - Top holds the FSM, ch counter, mask_q, shadow and output registers.
//  - Bench instantiates the real 16:1 select mux between sel and mux_out.
// TESTING
//  1. Reset: pulse rst_n low, then release -> sel=0, frame=0, frame_valid=0, busy=0, overrun=0.
//  2. SETTLE_CYC=1, mask=FFFF, mux in=16'hA5C3, 1-cycle start -> sel steps 0..15, each held
//     2 cycles; frame=16'hA5C3 with frame_valid exactly 33 cycles after start.
//  3. mask=16'h00FF, in=16'hFFFF -> frame=16'h00FF, valid after 8*2+8+1=25 cycles.
//     Also mask=0 -> frame=0 after 17 cycles.
//  4. cont=1, frame_ready=0 -> 1st frame held; overrun=1 at end of sweep 2, frame unchanged.
//     Then ready=1 in the DONE cycle of sweep 3 -> frame reloaded, frame_valid stays 1.
//  5. Reset asserted at ch=7 mid-sweep -> all outputs cleared at once. Next start with in=16'h1234
//     -> frame=16'h1234, no residue from the aborted sweep.
//  6. start pulsed while busy -> ignored: sweep timing and frame identical to test 2.

Source files
------------

// File: rtl/mux16_scan_pkg.sv
// rtl/mux16_scan_pkg.sv - shared constants and state type for the 16-channel mux scan controller
// Purpose: channel count, select width and scan FSM state encoding.
package mux16_scan_pkg;

  localparam int NCH   = 16;
  localparam int SEL_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } scan_state_t;

endpackage

// File: rtl/scan_settle_timer.sv
// rtl/scan_settle_timer.sv - loadable down-counter that times the mux settle window
// Purpose: after load, done is low for SETTLE_CYC-1 cycles and then high, so a
//          state that reloads on entry and leaves on done stays exactly SETTLE_CYC cycles.
// Ports:
//   clk   in  1  clock, rising edge
//   rst_n in  1  asynchronous active-low reset
//   load  in  1  restart the settle window
//   done  out 1  settle window has elapsed
module scan_settle_timer #(
  parameter int SETTLE_CYC = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic done
);

  localparam int CNT_W = $clog2(SETTLE_CYC + 1);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE_CYC - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/mux16_scan_ctrl.sv
// rtl/mux16_scan_ctrl.sv - sweeps a 16:1 mux select, samples its output and emits 16-bit frames
// Purpose: one-shot (start) or continuous (cont) sweeps over enabled channels with a
//          settle delay per channel; completed frames leave over a valid/ready handshake.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, cont         one-shot start pulse / continuous sweep level
//   ch_mask[15:0]       channel enables, latched at sweep start
//   sel[3:0], mux_out   select to the external mux and its sampled output
//   frame[15:0]         completed frame, bit i = channel i
//   frame_valid/ready   output handshake
//   busy, overrun       sweep in progress / sticky dropped-frame flag
module mux16_scan_ctrl
  import mux16_scan_pkg::*;
#(
  parameter int SETTLE_CYC = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cont,
  input  logic [NCH-1:0]   ch_mask,
  output logic [SEL_W-1:0] sel,
  input  logic             mux_out,
  output logic [NCH-1:0]   frame,
  output logic             frame_valid,
  input  logic             frame_ready,
  output logic             busy,
  output logic             overrun
);

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NCH - 1);

  scan_state_t      state, state_nxt;
  logic [SEL_W-1:0] ch, ch_nxt;
  logic [NCH-1:0]   mask_q;
  logic [NCH-1:0]   shadow;

  logic tmr_load, tmr_done;
  logic mask_load;
  logic shd_we, shd_bit;
  logic frame_load;
  logic ovr_set, ovr_clr;

  scan_settle_timer #(.SETTLE_CYC(SETTLE_CYC)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (tmr_load),
    .done  (tmr_done)
  );

  // Next-state and per-cycle control. The timer is reloaded on every SETTLE
  // entry, including the SETTLE->SETTLE hop past a masked channel.
  always_comb begin
    state_nxt  = state;
    ch_nxt     = ch;
    tmr_load   = 1'b0;
    mask_load  = 1'b0;
    shd_we     = 1'b0;
    shd_bit    = 1'b0;
    frame_load = 1'b0;
    ovr_set    = 1'b0;
    ovr_clr    = 1'b0;

    case (state)
      IDLE: begin
        if (start || cont) begin
          state_nxt = SETTLE;
          ch_nxt    = '0;
          mask_load = 1'b1;
          tmr_load  = 1'b1;
          ovr_clr   = start;
        end
      end

      SETTLE: begin
        if (!mask_q[ch]) begin
          shd_we  = 1'b1;
          shd_bit = 1'b0;
          if (ch == LAST_CH) begin
            state_nxt = DONE;
          end else begin
            ch_nxt   = ch + SEL_W'(1);
            tmr_load = 1'b1;
          end
        end else if (tmr_done) begin
          state_nxt = SAMPLE;
        end
      end

      SAMPLE: begin
        shd_we  = 1'b1;
        shd_bit = mux_out;
        if (ch == LAST_CH) begin
          state_nxt = DONE;
        end else begin
          state_nxt = SETTLE;
          ch_nxt    = ch + SEL_W'(1);
          tmr_load  = 1'b1;
        end
      end

      DONE: begin
        // Output slot is free if empty or being drained this very cycle.
        if (!frame_valid || frame_ready) begin
          frame_load = 1'b1;
        end else begin
          ovr_set = 1'b1;
        end
        ch_nxt = '0;
        if (cont) begin
          state_nxt = SETTLE;
          mask_load = 1'b1;
          tmr_load  = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
        ch_nxt    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ch          <= '0;
      mask_q      <= '0;
      shadow      <= '0;
      frame       <= '0;
      frame_valid <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state <= state_nxt;
      ch    <= ch_nxt;

      if (mask_load) begin
        mask_q <= ch_mask;
      end

      if (shd_we) begin
        shadow[ch] <= shd_bit;
      end

      if (frame_load) begin
        frame       <= shadow;
        frame_valid <= 1'b1;
      end else if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
      end

      if (ovr_clr) begin
        overrun <= 1'b0;
      end else if (ovr_set) begin
        overrun <= 1'b1;
      end
    end
  end

  // sel is the registered channel counter, so it only moves on SETTLE entry
  // (or back to 0 on IDLE entry) and cannot glitch inside a channel window.
  assign sel  = ch;
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mux16_scan_ctrl.sv
// tb/tb_mux16_scan_ctrl.sv - scoreboard bench for mux16_scan_ctrl with a behavioural 16:1 mux
module tb_mux16_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        cont;
  logic [15:0] ch_mask;
  logic [3:0]  sel;
  logic        mux_out;
  logic [15:0] frame;
  logic        frame_valid;
  logic        frame_ready;
  logic        busy;
  logic        overrun;
  logic [15:0] mux_in;

  always #5 clk = ~clk;

  // the 16:1 select mux under control
  assign mux_out = mux_in[sel];

  mux16_scan_ctrl #(.SETTLE_CYC(1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .cont        (cont),
    .ch_mask     (ch_mask),
    .sel         (sel),
    .mux_out     (mux_out),
    .frame       (frame),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .busy        (busy),
    .overrun     (overrun)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] frame;
    int          edge_n;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: a new frame is on the bus when valid rises, or when valid stays
  // high right after an accept (reload in the same cycle).
  logic prev_valid = 1'b0;
  logic prev_ready = 1'b0;
  exp_t mon_e;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && frame_valid === 1'b1 && (!prev_valid || prev_ready)) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: got %0h expected none (cycle %0d)", frame, cyc);
        end else begin
          mon_e = sb.pop_front();
          chk("frame", {16'h0, frame}, {16'h0, mon_e.frame});
          chk("valid_edge", cyc, mon_e.edge_n);
        end
      end
      prev_valid = frame_valid;
      prev_ready = frame_ready;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int e);
    while (cyc < e) tick();
  endtask

  task automatic push_exp(input logic [15:0] f, input int e);
    exp_t x;
    x.frame  = f;
    x.edge_n = e;
    sb.push_back(x);
  endtask

  // Start pulse sampled at edge k = cyc+1; returns just after edge k.
  task automatic issue_start(input logic [15:0] m, input logic [15:0] din,
                             input logic [15:0] exp, input int lat);
    tick();
    ch_mask = m;
    mux_in  = din;
    start   = 1'b1;
    push_exp(exp, cyc + 1 + lat);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 300) begin
      tick();
      n++;
    end
    tick();
    tick();
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got pending=%0d busy=%0b expected drained", name, sb.size(), busy);
    end
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_sel"},     {28'h0, sel}, 32'h0);
    chk({tag, "_frame"},   {16'h0, frame}, 32'h0);
    chk({tag, "_valid"},   {31'h0, frame_valid}, 32'h0);
    chk({tag, "_busy"},    {31'h0, busy}, 32'h0);
    chk({tag, "_overrun"}, {31'h0, overrun}, 32'h0);
  endtask

  initial begin
    int k;
    int bad;

    rst_n       = 1'b0;
    start       = 1'b0;
    cont        = 1'b0;
    ch_mask     = 16'h0;
    mux_in      = 16'h0;
    frame_ready = 1'b1;

    // 1. reset
    #2;
    chk_cleared("rst_hold");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk_cleared("rst_rel");

    // 2. full mask, SETTLE_CYC=1: sel 0..15 each held 2 cycles, valid at +33
    issue_start(16'hFFFF, 16'hA5C3, 16'hA5C3, 33);
    bad = 0;
    for (int j = 0; j < 32; j++) begin
      @(negedge clk);
      if (sel !== 4'(j >> 1)) bad++;
      @(posedge clk);
    end
    chk("sel_sequence_mismatches", bad, 0);
    wait_drain("full_sweep");
    chk("overrun_after_full", {31'h0, overrun}, 32'h0);

    // 3. partial and empty masks
    issue_start(16'h00FF, 16'hFFFF, 16'h00FF, 25);
    wait_drain("half_mask");
    issue_start(16'h0000, 16'hFFFF, 16'h0000, 17);
    wait_drain("zero_mask");

    // 6. start pulses while busy are ignored; ch_mask changes mid-sweep are not latched
    issue_start(16'hFFFF, 16'hA5C3, 16'hA5C3, 33);
    for (int j = 1; j <= 34; j++) begin
      start   = (j == 5 || j == 20 || j == 33);
      ch_mask = start ? 16'h0000 : 16'hFFFF;
      tick();
    end
    start   = 1'b0;
    ch_mask = 16'hFFFF;
    chk("busy_after_ignored_starts", {31'h0, busy}, 32'h0);
    wait_drain("busy_start");

    // 4. continuous sweeps with back-pressure
    tick();
    frame_ready = 1'b0;
    ch_mask     = 16'hFFFF;
    mux_in      = 16'h3C5A;
    cont        = 1'b1;
    k           = cyc + 1;
    push_exp(16'h3C5A, k + 33);
    run_to(k + 33);
    mux_in = 16'h0F0F;
    run_to(k + 65);
    @(negedge clk);
    chk("overrun_before_drop", {31'h0, overrun}, 32'h0);
    run_to(k + 66);
    mux_in = 16'hF0F0;
    @(negedge clk);
    chk("overrun_on_drop", {31'h0, overrun}, 32'h1);
    chk("frame_held_on_drop", {16'h0, frame}, 32'h3C5A);
    chk("valid_held_on_drop", {31'h0, frame_valid}, 32'h1);
    run_to(k + 98);
    frame_ready = 1'b1;
    push_exp(16'hF0F0, k + 99);
    run_to(k + 99);
    cont = 1'b0;
    push_exp(16'hF0F0, k + 132);
    @(negedge clk);
    chk("valid_kept_on_reload", {31'h0, frame_valid}, 32'h1);
    wait_drain("cont_sweeps");
    chk("overrun_sticky", {31'h0, overrun}, 32'h1);

    // 5. asynchronous reset at ch=7 mid-sweep
    tick();
    ch_mask = 16'hFFFF;
    mux_in  = 16'hFFFF;
    start   = 1'b1;
    k       = cyc + 1;
    tick();
    start = 1'b0;
    run_to(k + 14);
    chk("sel_before_abort", {28'h0, sel}, 32'h7);
    rst_n = 1'b0;
    #1;
    chk_cleared("abort");
    tick();
    tick();
    rst_n = 1'b1;
    issue_start(16'hFFFF, 16'h1234, 16'h1234, 33);
    wait_drain("after_abort");

    chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
